// File: rtl/ehl_gpio_pkg.sv
// Shared definitions for the GPIO APB front-end: register index map,
// address-field positions, alias op codes and the transfer FSM encoding.
package ehl_gpio_pkg;

  localparam int NREG        = 11;
  localparam int REG_IDX_LSB = 4;
  localparam int OP_LSB      = 2;

  localparam logic [3:0] GDOR = 4'd0;
  localparam logic [3:0] GOER = 4'd1;
  localparam logic [3:0] GAFR = 4'd2;
  localparam logic [3:0] GPER = 4'd3;
  localparam logic [3:0] GPTR = 4'd4;
  localparam logic [3:0] GIER = 4'd5;
  localparam logic [3:0] GISR = 4'd6;
  localparam logic [3:0] GIFR = 4'd7;
  localparam logic [3:0] GDIR = 4'd8;
  localparam logic [3:0] GCMR = 4'd9;
  localparam logic [3:0] GFMR = 4'd10;

  typedef enum logic [1:0] {
    OP_BASE = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_INV  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WSTB  = 3'd1,
    RSTB  = 3'd2,
    RWAIT = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/ehl_gpio_apb_decode.sv
// Combinational address decode: paddr/pwrite -> one-hot register select,
// alias op and an error flag for the current direction.
module ehl_gpio_apb_decode
  import ehl_gpio_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  output logic [NREG-1:0]   reg_sel,
  output op_e               op,
  output logic              err
);

  logic [3:0] idx;
  logic       mapped;
  logic       wr_err;
  logic       unused_addr;

  assign idx         = paddr[REG_IDX_LSB +: 4];
  assign op          = op_e'(paddr[OP_LSB +: 2]);
  assign mapped      = (idx < 4'(NREG));
  // byte-lane bits and anything above the register index carry no meaning
  assign unused_addr = ^{paddr[1:0], paddr >> 8};

  // one-hot select of the addressed register slot
  always_comb begin
    reg_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      reg_sel[i] = (idx == 4'(i));
    end
  end

  // GDIR is read-only; GIFR only clears, so SET/INV on it are rejected
  always_comb begin
    wr_err = !mapped || (idx == GDIR) ||
             ((idx == GIFR) && ((op == OP_SET) || (op == OP_INV)));
    err    = pwrite ? wr_err : !mapped;
  end

endmodule

// File: rtl/ehl_gpio_apb_if.sv
// APB slave front-end for the GPIO core. Turns APB transfers into one-cycle
// write/set/clr/inv/read strobes and returns core data with wait states that
// match the core read latency. All outputs come straight from flops.
// Optional build macro: EHL_GPIO_APB_PROT_EN (unprivileged writes rejected).
//
//   state | meaning
//   IDLE  | waiting for an APB access phase
//   WSTB  | write strobe out, pready/pslverr returned
//   RSTB  | read strobe out, first read cycle
//   RWAIT | read strobe held while registered core data settles
//   RESP  | captured read data returned with pready
module ehl_gpio_apb_if
  import ehl_gpio_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int READ_LATENCY = 0,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  input  logic [2:0]        pprot,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [WIDTH-1:0]  data_out,
  output logic [WIDTH-1:0]  data_in,
  output logic              write_gdor, write_goer, write_gafr, write_gper,
  output logic              write_gptr, write_gier, write_gisr, write_gcmr,
  output logic              write_gfmr,
  output logic [WIDTH-1:0]  set_gdor, set_goer, set_gafr, set_gper, set_gptr,
  output logic [WIDTH-1:0]  set_gier, set_gisr, set_gcmr, set_gfmr,
  output logic [WIDTH-1:0]  clr_gdor, clr_goer, clr_gafr, clr_gper, clr_gptr,
  output logic [WIDTH-1:0]  clr_gier, clr_gisr, clr_gcmr, clr_gfmr, clr_gifr,
  output logic [WIDTH-1:0]  inv_gdor, inv_goer, inv_gafr, inv_gper, inv_gptr,
  output logic [WIDTH-1:0]  inv_gier, inv_gisr, inv_gcmr, inv_gfmr,
  output logic              read_gdor, read_goer, read_gafr, read_gper,
  output logic              read_gptr, read_gier, read_gisr, read_gifr,
  output logic              read_gdir, read_gcmr, read_gfmr
);

  state_e            state_q, state_d;
  logic              cnt_q, cnt_d;
  logic              rerr_q, rerr_d;
  logic [31:0]       prdata_q, prdata_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [WIDTH-1:0]  data_in_q, data_in_d;
  logic [NREG-1:0]   wr_q, wr_d;
  logic [NREG-1:0]   rd_q, rd_d;
  logic [WIDTH-1:0]  set_q [NREG];
  logic [WIDTH-1:0]  set_d [NREG];
  logic [WIDTH-1:0]  clr_q [NREG];
  logic [WIDTH-1:0]  clr_d [NREG];
  logic [WIDTH-1:0]  inv_q [NREG];
  logic [WIDTH-1:0]  inv_d [NREG];

  logic [NREG-1:0]   dec_sel;
  op_e               dec_op;
  logic              dec_err;
  logic              prot_err;
  logic [WIDTH-1:0]  wdata;
  logic              unused_in;
  logic              unused_q;

  ehl_gpio_apb_decode #(.ADDR_W(ADDR_W)) u_decode (
    .paddr   (paddr),
    .pwrite  (pwrite),
    .reg_sel (dec_sel),
    .op      (dec_op),
    .err     (dec_err)
  );

  assign wdata = pwdata[WIDTH-1:0];

`ifdef EHL_GPIO_APB_PROT_EN
  assign prot_err = pwrite && !pprot[0];
`else
  assign prot_err = 1'b0;
`endif

  // pwdata bits above WIDTH and (by default) pprot are don't-cares
  assign unused_in = ^{pwdata, pprot};
  // slots with no matching core strobe port (GIFR write/set/inv, GDIR writes)
  assign unused_q  = ^{wr_q[GIFR], wr_q[GDIR], set_q[GIFR], set_q[GDIR],
                       clr_q[GDIR], inv_q[GIFR], inv_q[GDIR]};

  // next state and next value of every registered output
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rerr_d    = rerr_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    data_in_d = '0;
    wr_d      = '0;
    rd_d      = '0;
    for (int i = 0; i < NREG; i++) begin
      set_d[i] = '0;
      clr_d[i] = '0;
      inv_d[i] = '0;
    end

    case (state_q)
      IDLE: begin
        if (psel && penable) begin
          if (pwrite) begin
            state_d  = WSTB;
            pready_d = 1'b1;
            if (dec_err || prot_err) begin
              pslverr_d = 1'b1;
            end else begin
              case (dec_op)
                OP_BASE: begin
                  // base write of GIFR is write-1-to-clear
                  if (dec_sel[GIFR]) begin
                    clr_d[GIFR] = wdata;
                  end else begin
                    wr_d      = dec_sel;
                    data_in_d = wdata;
                  end
                end
                OP_SET: begin
                  for (int i = 0; i < NREG; i++)
                    if (dec_sel[i]) set_d[i] = wdata;
                end
                OP_CLR: begin
                  for (int i = 0; i < NREG; i++)
                    if (dec_sel[i]) clr_d[i] = wdata;
                end
                default: begin
                  for (int i = 0; i < NREG; i++)
                    if (dec_sel[i]) inv_d[i] = wdata;
                end
              endcase
            end
          end else begin
            state_d = RSTB;
            cnt_d   = 1'(READ_LATENCY);
            rerr_d  = dec_err;
            if (!dec_err) rd_d = dec_sel;
          end
        end
      end
      WSTB: state_d = IDLE;
      RSTB, RWAIT: begin
        if (cnt_q == 1'b0) begin
          state_d   = RESP;
          pready_d  = psel;
          pslverr_d = psel && rerr_q;
          prdata_d  = '0;
          if (!rerr_q) prdata_d[WIDTH-1:0] = data_out;
        end else begin
          state_d = RWAIT;
          cnt_d   = cnt_q - 1'b1;
          rd_d    = rd_q;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset drops any pending strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 1'b0;
      rerr_q    <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      data_in_q <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      for (int i = 0; i < NREG; i++) begin
        set_q[i] <= '0;
        clr_q[i] <= '0;
        inv_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rerr_q    <= rerr_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      data_in_q <= data_in_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      for (int i = 0; i < NREG; i++) begin
        set_q[i] <= set_d[i];
        clr_q[i] <= clr_d[i];
        inv_q[i] <= inv_d[i];
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;
  assign data_in = data_in_q;

  assign write_gdor = wr_q[GDOR];
  assign write_goer = wr_q[GOER];
  assign write_gafr = wr_q[GAFR];
  assign write_gper = wr_q[GPER];
  assign write_gptr = wr_q[GPTR];
  assign write_gier = wr_q[GIER];
  assign write_gisr = wr_q[GISR];
  assign write_gcmr = wr_q[GCMR];
  assign write_gfmr = wr_q[GFMR];

  assign set_gdor = set_q[GDOR];
  assign set_goer = set_q[GOER];
  assign set_gafr = set_q[GAFR];
  assign set_gper = set_q[GPER];
  assign set_gptr = set_q[GPTR];
  assign set_gier = set_q[GIER];
  assign set_gisr = set_q[GISR];
  assign set_gcmr = set_q[GCMR];
  assign set_gfmr = set_q[GFMR];

  assign clr_gdor = clr_q[GDOR];
  assign clr_goer = clr_q[GOER];
  assign clr_gafr = clr_q[GAFR];
  assign clr_gper = clr_q[GPER];
  assign clr_gptr = clr_q[GPTR];
  assign clr_gier = clr_q[GIER];
  assign clr_gisr = clr_q[GISR];
  assign clr_gcmr = clr_q[GCMR];
  assign clr_gfmr = clr_q[GFMR];
  assign clr_gifr = clr_q[GIFR];

  assign inv_gdor = inv_q[GDOR];
  assign inv_goer = inv_q[GOER];
  assign inv_gafr = inv_q[GAFR];
  assign inv_gper = inv_q[GPER];
  assign inv_gptr = inv_q[GPTR];
  assign inv_gier = inv_q[GIER];
  assign inv_gisr = inv_q[GISR];
  assign inv_gcmr = inv_q[GCMR];
  assign inv_gfmr = inv_q[GFMR];

  assign read_gdor = rd_q[GDOR];
  assign read_goer = rd_q[GOER];
  assign read_gafr = rd_q[GAFR];
  assign read_gper = rd_q[GPER];
  assign read_gptr = rd_q[GPTR];
  assign read_gier = rd_q[GIER];
  assign read_gisr = rd_q[GISR];
  assign read_gifr = rd_q[GIFR];
  assign read_gdir = rd_q[GDIR];
  assign read_gcmr = rd_q[GCMR];
  assign read_gfmr = rd_q[GFMR];

endmodule

// File: tb/tb_ehl_gpio_apb_if.sv
// Directed bench for ehl_gpio_apb_if with WIDTH=8, READ_LATENCY=1.
module tb_ehl_gpio_apb_if;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         psel, penable, pwrite;
  logic [7:0]   paddr;
  logic [31:0]  pwdata;
  logic [2:0]   pprot;
  logic [31:0]  prdata;
  logic         pready, pslverr;
  logic [W-1:0] data_out, data_in;
  logic write_gdor, write_goer, write_gafr, write_gper, write_gptr;
  logic write_gier, write_gisr, write_gcmr, write_gfmr;
  logic [W-1:0] set_gdor, set_goer, set_gafr, set_gper, set_gptr;
  logic [W-1:0] set_gier, set_gisr, set_gcmr, set_gfmr;
  logic [W-1:0] clr_gdor, clr_goer, clr_gafr, clr_gper, clr_gptr;
  logic [W-1:0] clr_gier, clr_gisr, clr_gcmr, clr_gfmr, clr_gifr;
  logic [W-1:0] inv_gdor, inv_goer, inv_gafr, inv_gper, inv_gptr;
  logic [W-1:0] inv_gier, inv_gisr, inv_gcmr, inv_gfmr;
  logic read_gdor, read_goer, read_gafr, read_gper, read_gptr, read_gier;
  logic read_gisr, read_gifr, read_gdir, read_gcmr, read_gfmr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ehl_gpio_apb_if #(.WIDTH(W), .READ_LATENCY(1), .ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pprot(pprot),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .data_out(data_out), .data_in(data_in),
    .write_gdor(write_gdor), .write_goer(write_goer), .write_gafr(write_gafr),
    .write_gper(write_gper), .write_gptr(write_gptr), .write_gier(write_gier),
    .write_gisr(write_gisr), .write_gcmr(write_gcmr), .write_gfmr(write_gfmr),
    .set_gdor(set_gdor), .set_goer(set_goer), .set_gafr(set_gafr),
    .set_gper(set_gper), .set_gptr(set_gptr), .set_gier(set_gier),
    .set_gisr(set_gisr), .set_gcmr(set_gcmr), .set_gfmr(set_gfmr),
    .clr_gdor(clr_gdor), .clr_goer(clr_goer), .clr_gafr(clr_gafr),
    .clr_gper(clr_gper), .clr_gptr(clr_gptr), .clr_gier(clr_gier),
    .clr_gisr(clr_gisr), .clr_gcmr(clr_gcmr), .clr_gfmr(clr_gfmr),
    .clr_gifr(clr_gifr),
    .inv_gdor(inv_gdor), .inv_goer(inv_goer), .inv_gafr(inv_gafr),
    .inv_gper(inv_gper), .inv_gptr(inv_gptr), .inv_gier(inv_gier),
    .inv_gisr(inv_gisr), .inv_gcmr(inv_gcmr), .inv_gfmr(inv_gfmr),
    .read_gdor(read_gdor), .read_goer(read_goer), .read_gafr(read_gafr),
    .read_gper(read_gper), .read_gptr(read_gptr), .read_gier(read_gier),
    .read_gisr(read_gisr), .read_gifr(read_gifr), .read_gdir(read_gdir),
    .read_gcmr(read_gcmr), .read_gfmr(read_gfmr)
  );

  wire [8:0]   wr_vec = {write_gdor, write_goer, write_gafr, write_gper,
                         write_gptr, write_gier, write_gisr, write_gcmr,
                         write_gfmr};
  wire [10:0]  rd_vec = {read_gdor, read_goer, read_gafr, read_gper, read_gptr,
                         read_gier, read_gisr, read_gifr, read_gdir, read_gcmr,
                         read_gfmr};
  wire [28*W-1:0] all_vec = {set_gdor, set_goer, set_gafr, set_gper, set_gptr,
                             set_gier, set_gisr, set_gcmr, set_gfmr,
                             clr_gdor, clr_goer, clr_gafr, clr_gper, clr_gptr,
                             clr_gier, clr_gisr, clr_gcmr, clr_gfmr, clr_gifr,
                             inv_gdor, inv_goer, inv_gafr, inv_gper, inv_gptr,
                             inv_gier, inv_gisr, inv_gcmr, inv_gfmr};

  // running counts of cycles with strobes active
  int stb_cyc = 0;
  int rd_cyc  = 0;
  int gdir_cyc = 0;
  always @(negedge clk) begin
    if ((|wr_vec) || (|all_vec)) stb_cyc++;
    if (|rd_vec) rd_cyc++;
    if (read_gdir) gdir_cyc++;
  end

  // values seen in the pready cycle of the last transfer
  int          lat;
  int          stb_n, rd_n, gdir_n;
  logic [31:0] snap_rd;
  logic        snap_err;
  logic [8:0]  snap_wr;
  logic [W-1:0] snap_din, snap_inv_gier, snap_clr_gifr, snap_set_gper;
  int          snap_ones;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] data);
    int s0, r0, g0;
    s0 = stb_cyc; r0 = rd_cyc; g0 = gdir_cyc;
    lat = -1; snap_rd = 'x; snap_err = 1'bx;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (pready) begin
        lat = i; snap_rd = prdata; snap_err = pslverr; snap_wr = wr_vec;
        snap_din = data_in; snap_inv_gier = inv_gier; snap_clr_gifr = clr_gifr;
        snap_set_gper = set_gper; snap_ones = $countones(all_vec);
        break;
      end
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    stb_n = stb_cyc - s0; rd_n = rd_cyc - r0; gdir_n = gdir_cyc - g0;
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pprot = 3'b001; data_out = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_pready", pready, 0);
    chk("rst_pslverr", pslverr, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_strobes", {wr_vec, rd_vec, |all_vec}, 0);

    // base write to GDOR, upper pwdata bits ignored
    xfer(1'b1, 8'h00, 32'hFFFF_FFA5);
    chk("w_gdor_lat", lat, 1);
    chk("w_gdor_err", snap_err, 0);
    chk("w_gdor_wr", snap_wr, 9'h100);
    chk("w_gdor_din", snap_din, 8'hA5);
    chk("w_gdor_vec", snap_ones, 0);
    chk("w_gdor_ncyc", stb_n, 1);

    // INV alias of GIER
    xfer(1'b1, 8'h5C, 32'h0000_000F);
    chk("w_ier_inv_lat", lat, 1);
    chk("w_ier_inv_val", snap_inv_gier, 8'h0F);
    chk("w_ier_inv_ones", snap_ones, 4);
    chk("w_ier_inv_wr", snap_wr, 0);
    chk("w_ier_inv_ncyc", stb_n, 1);

    // SET alias of GPER
    xfer(1'b1, 8'h34, 32'h0000_0066);
    chk("w_per_set_val", snap_set_gper, 8'h66);
    chk("w_per_set_ones", snap_ones, 4);

    // read GDIR with registered core output
    data_out = 8'h3C;
    xfer(1'b0, 8'h80, 32'h0);
    chk("r_gdir_lat", lat, 3);
    chk("r_gdir_data", snap_rd, 32'h3C);
    chk("r_gdir_err", snap_err, 0);
    chk("r_gdir_cyc", gdir_n, 2);
    chk("r_gdir_anyrd", rd_n, 2);

    // reset while the read is in RWAIT
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h80;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_rdgdir_before", read_gdir, 1);
    @(posedge clk); #1;
    reset = 1'b0; psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd", rd_vec, 0);
    chk("rst_mid_pready", pready, 0);
    chk("rst_mid_prdata", prdata, 0);
    chk("rst_mid_vec", {wr_vec, |all_vec}, 0);

    // following read completes normally (alias read returns base value)
    data_out = 8'h5A;
    xfer(1'b0, 8'h04, 32'h0);
    chk("r_after_rst_lat", lat, 3);
    chk("r_after_rst_data", snap_rd, 32'h5A);
    chk("r_after_rst_cyc", rd_n, 2);

    // error: write to GDIR
    xfer(1'b1, 8'h80, 32'h0000_00FF);
    chk("e_wgdir_lat", lat, 1);
    chk("e_wgdir_err", snap_err, 1);
    chk("e_wgdir_stb", stb_n, 0);

    // error: SET alias of GIFR
    xfer(1'b1, 8'h74, 32'h0000_00FF);
    chk("e_gifr_set_err", snap_err, 1);
    chk("e_gifr_set_stb", stb_n, 0);

    // error: unmapped read
    xfer(1'b0, 8'hB0, 32'h0);
    chk("e_rd_b0_lat", lat, 3);
    chk("e_rd_b0_err", snap_err, 1);
    chk("e_rd_b0_data", snap_rd, 0);
    chk("e_rd_b0_rd", rd_n, 0);

    // GIFR CLR alias, privileged
    xfer(1'b1, 8'h78, 32'h0000_0042);
    chk("w_gifr_clr_val", snap_clr_gifr, 8'h42);
    chk("w_gifr_clr_err", snap_err, 0);

    // GIFR base write with unprivileged pprot
    pprot = 3'b000;
    xfer(1'b1, 8'h70, 32'h0000_0081);
`ifdef EHL_GPIO_APB_PROT_EN
    chk("w_gifr_base_err", snap_err, 1);
    chk("w_gifr_base_val", snap_clr_gifr, 8'h00);
`else
    chk("w_gifr_base_err", snap_err, 0);
    chk("w_gifr_base_val", snap_clr_gifr, 8'h81);
`endif
    pprot = 3'b001;

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
